// File: rtl/vsetvl_unit.sv
// vsetvl_unit: executes vsetvli/vsetivli/vsetvl, computes VLMAX and the new vl,
// and commits the architectural vtype/vl state seen by the vector datapath.
module vsetvl_unit #(
    parameter int VLEN = 128,
    parameter int XLEN = 32,
    parameter int ELEN = 64,
    localparam int VL_W = $clog2(VLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_vsew,
    input  logic [2:0]      req_vlmul,
    input  logic [XLEN-1:0] req_avl,
    input  logic [1:0]      req_mode,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_vl,
    output logic [VL_W-1:0] csr_vl,
    output logic [2:0]      csr_vsew,
    output logic [2:0]      csr_vlmul,
    output logic            csr_vill,
    output logic [VL_W-1:0] csr_vlmax
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q;
    logic            req_ready_q;
    logic            resp_valid_q;
    logic [2:0]      vsew_q;
    logic [2:0]      vlmul_q;
    logic [XLEN-1:0] avl_q;
    logic [1:0]      mode_q;
    logic [XLEN-1:0] resp_vl_q;
    logic [VL_W-1:0] csr_vl_q;
    logic [2:0]      csr_vsew_q;
    logic [2:0]      csr_vlmul_q;
    logic            csr_vill_q;
    logic [VL_W-1:0] csr_vlmax_q;

    logic [2:0]      sew_shift;
    logic [VL_W-1:0] vlmax_c;
    logic            illegal;
    logic [XLEN-1:0] vl_d;
    logic [VL_W-1:0] vlmax_d;
    logic [2:0]      vsew_d;
    logic [2:0]      vlmul_d;
    logic            vill_d;

    // Shift right first: VLEN >= 64 keeps VLEN/SEW exact, and the
    // result never exceeds VLEN, so VL_W bits suffice throughout.
    always_comb begin
        sew_shift = {1'b0, vsew_q[1:0]} + 3'd3;
        vlmax_c   = (VL_W'(VLEN) >> sew_shift) << vlmul_q[1:0];
        illegal   = vsew_q[2] | vlmul_q[2] | (mode_q == 2'b11)
                  | ((32'd8 << vsew_q[1:0]) > ELEN);
        vl_d      = '0;
        unique case (mode_q)
            2'b00: vl_d = (avl_q < XLEN'(vlmax_c)) ? avl_q : XLEN'(vlmax_c);
            2'b01: vl_d = XLEN'(vlmax_c);
            2'b10: begin
                vl_d = XLEN'(csr_vl_q);
                if (csr_vill_q || (csr_vl_q > vlmax_c)) illegal = 1'b1;
            end
            default: vl_d = '0;
        endcase
        if (illegal) begin
            vl_d    = '0;
            vlmax_d = '0;
            vsew_d  = '0;
            vlmul_d = '0;
            vill_d  = 1'b1;
        end else begin
            vlmax_d = vlmax_c;
            vsew_d  = vsew_q;
            vlmul_d = vlmul_q;
            vill_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            vsew_q       <= '0;
            vlmul_q      <= '0;
            avl_q        <= '0;
            mode_q       <= '0;
            resp_vl_q    <= '0;
            csr_vl_q     <= '0;
            csr_vsew_q   <= '0;
            csr_vlmul_q  <= '0;
            csr_vill_q   <= 1'b1;
            csr_vlmax_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        vsew_q      <= req_vsew;
                        vlmul_q     <= req_vlmul;
                        avl_q       <= req_avl;
                        mode_q      <= req_mode;
                        req_ready_q <= 1'b0;
                        state_q     <= CALC;
                    end
                end
                CALC: begin
                    resp_vl_q    <= vl_d;
                    csr_vl_q     <= VL_W'(vl_d);
                    csr_vsew_q   <= vsew_d;
                    csr_vlmul_q  <= vlmul_d;
                    csr_vill_q   <= vill_d;
                    csr_vlmax_q  <= vlmax_d;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_vl    = resp_vl_q;
    assign csr_vl     = csr_vl_q;
    assign csr_vsew   = csr_vsew_q;
    assign csr_vlmul  = csr_vlmul_q;
    assign csr_vill   = csr_vill_q;
    assign csr_vlmax  = csr_vlmax_q;

endmodule

// File: tb/tb_vsetvl_unit.sv
// Directed bench for vsetvl_unit: expected results are queued at request time
// and compared when the response appears.
module tb_vsetvl_unit;

    localparam int VLEN = 128;
    localparam int XLEN = 32;
    localparam int ELEN = 64;
    localparam int VL_W = $clog2(VLEN) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_vsew;
    logic [2:0]      req_vlmul;
    logic [XLEN-1:0] req_avl;
    logic [1:0]      req_mode;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_vl;
    logic [VL_W-1:0] csr_vl;
    logic [2:0]      csr_vsew;
    logic [2:0]      csr_vlmul;
    logic            csr_vill;
    logic [VL_W-1:0] csr_vlmax;

    typedef struct packed {
        logic [31:0] vl;
        logic [2:0]  sew;
        logic [2:0]  lmul;
        logic        vill;
        logic [7:0]  vlmax;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    vsetvl_unit #(.VLEN(VLEN), .XLEN(XLEN), .ELEN(ELEN)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_vsew(req_vsew), .req_vlmul(req_vlmul),
        .req_avl(req_avl), .req_mode(req_mode),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_vl(resp_vl), .csr_vl(csr_vl),
        .csr_vsew(csr_vsew), .csr_vlmul(csr_vlmul),
        .csr_vill(csr_vill), .csr_vlmax(csr_vlmax)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] vl, input logic [2:0] s,
                                input logic [2:0] l, input logic v, input logic [7:0] m);
        exp_t e;
        e.vl = vl; e.sew = s; e.lmul = l; e.vill = v; e.vlmax = m;
        return e;
    endfunction

    // Waits (bounded) for resp_valid, then compares against the queue head.
    task automatic wait_and_compare(input string tag, input int want_wait);
        exp_t e;
        int n = 0;
        while (!resp_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, want_wait);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_resp_vl"}, resp_vl, e.vl);
            check({tag, "_csr_vl"}, 32'(csr_vl), e.vl);
            check({tag, "_vsew"}, 32'(csr_vsew), 32'(e.sew));
            check({tag, "_vlmul"}, 32'(csr_vlmul), 32'(e.lmul));
            check({tag, "_vill"}, 32'(csr_vill), 32'(e.vill));
            check({tag, "_vlmax"}, 32'(csr_vlmax), 32'(e.vlmax));
        end
    endtask

    task automatic run_req(input string tag, input logic [2:0] s, input logic [2:0] l,
                           input logic [31:0] a, input logic [1:0] m, input exp_t e);
        exp_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b1; req_vsew = s; req_vlmul = l; req_avl = a; req_mode = m;
        @(negedge clk);
        check({tag, "_ready_idle"}, 32'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_vsew = 3'($urandom); req_vlmul = 3'($urandom);
        req_avl = $urandom; req_mode = 2'($urandom);
        @(negedge clk);
        check({tag, "_calc_valid"}, 32'(resp_valid), 0);
        check({tag, "_calc_ready"}, 32'(req_ready), 0);
        @(negedge clk);
        wait_and_compare(tag, 0);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        @(negedge clk);
        check({tag, "_ready_after"}, 32'(req_ready), 1);
        check({tag, "_valid_after"}, 32'(resp_valid), 0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
        req_vsew = '0; req_vlmul = '0; req_avl = '0; req_mode = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_ready", 32'(req_ready), 1);
        check("rst_valid", 32'(resp_valid), 0);
        check("rst_vill", 32'(csr_vill), 1);
        check("rst_vl", 32'(csr_vl), 0);
        check("rst_vlmax", 32'(csr_vlmax), 0);
        check("rst_resp_vl", resp_vl, 0);

        run_req("avl5", 3'b010, 3'b001, 32'd5, 2'b00, mk(5, 2, 1, 0, 8));
        run_req("avl100", 3'b010, 3'b001, 32'd100, 2'b00, mk(8, 2, 1, 0, 8));
        run_req("avlmax", 3'b010, 3'b001, 32'hFFFF_FFFF, 2'b00, mk(8, 2, 1, 0, 8));
        run_req("avl256", 3'b010, 3'b001, 32'd256, 2'b00, mk(8, 2, 1, 0, 8));
        run_req("vlmax128", 3'b000, 3'b011, 32'd3, 2'b01, mk(128, 0, 3, 0, 128));
        run_req("sew_bad", 3'b100, 3'b000, 32'd3, 2'b00, mk(0, 0, 0, 1, 0));
        run_req("keep_vill", 3'b000, 3'b000, 32'd0, 2'b10, mk(0, 0, 0, 1, 0));
        run_req("clear_vill", 3'b011, 3'b011, 32'd4, 2'b00, mk(4, 3, 3, 0, 16));
        run_req("lmul_bad", 3'b000, 3'b101, 32'd4, 2'b00, mk(0, 0, 0, 1, 0));
        run_req("mode11", 3'b000, 3'b000, 32'd4, 2'b11, mk(0, 0, 0, 1, 0));
        run_req("avl0", 3'b010, 3'b000, 32'd0, 2'b00, mk(0, 2, 0, 0, 4));
        run_req("set8a", 3'b010, 3'b001, 32'd8, 2'b00, mk(8, 2, 1, 0, 8));
        run_req("keep_shrink", 3'b011, 3'b001, 32'd0, 2'b10, mk(0, 0, 0, 1, 0));
        run_req("set8b", 3'b010, 3'b001, 32'd8, 2'b00, mk(8, 2, 1, 0, 8));
        run_req("keep_ok", 3'b001, 3'b000, 32'd0, 2'b10, mk(8, 1, 0, 0, 8));

        // Stall with resp_ready low while a second request pulses and then holds.
        exp_q.push_back(mk(6, 2, 1, 0, 8));
        @(posedge clk); #1;
        req_valid = 1'b1; req_vsew = 3'b010; req_vlmul = 3'b001;
        req_avl = 32'd6; req_mode = 2'b00;
        @(posedge clk); #1;
        req_vsew = 3'b000; req_vlmul = 3'b000; req_avl = 32'd20; req_mode = 2'b00;
        req_valid = 1'b0;
        @(negedge clk);
        check("stall_calc_ready", 32'(req_ready), 0);
        @(negedge clk);
        wait_and_compare("stall", 0);
        for (int i = 0; i < 4; i++) begin
            req_valid = ~req_valid;
            @(negedge clk);
            check("stall_resp_vl", resp_vl, 6);
            check("stall_csr_vl", 32'(csr_vl), 6);
            check("stall_ready", 32'(req_ready), 0);
            check("stall_valid", 32'(resp_valid), 1);
        end
        exp_q.push_back(mk(16, 0, 0, 0, 16));
        req_valid = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        @(negedge clk);
        check("stall_idle_ready", 32'(req_ready), 1);
        check("stall_idle_valid", 32'(resp_valid), 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("second_calc_ready", 32'(req_ready), 0);
        @(negedge clk);
        wait_and_compare("second", 0);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;

        // Reset during CALC drops the request.
        @(posedge clk); #1;
        req_valid = 1'b1; req_vsew = 3'b010; req_vlmul = 3'b000;
        req_avl = 32'd2; req_mode = 2'b00;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_vill", 32'(csr_vill), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rstcalc_valid", 32'(resp_valid), 0);
        end
        check("rstcalc_ready", 32'(req_ready), 1);
        check("rstcalc_vill", 32'(csr_vill), 1);
        check("rstcalc_vl", 32'(csr_vl), 0);
        check("rstcalc_resp_vl", resp_vl, 0);
        check("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
